// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: elevator car controller serving a bitmap of floor calls in
// SCAN order. Floor travel time and door dwell are timed internally in
// CLOCK_50 cycles. Drives current floor, direction and door status.
module lift_scan_ctrl #(
    parameter int unsigned N_FLOORS        = 9,
    parameter int unsigned FLOOR_W         = 4,
    parameter int unsigned TICKS_PER_FLOOR = 50_000_000,
    parameter int unsigned DOOR_TICKS      = 100_000_000
) (
    input  logic                CLOCK_50,
    input  logic                Reset,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic                req_err,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [1:0]          dir,
    output logic                moving,
    output logic                door_open,
    output logic                arrive,
    output logic [N_FLOORS-1:0] pending
);

    localparam int unsigned        CNT_W       = 32;
    localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TICKS_PER_FLOOR - 1);
    localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(N_FLOORS);

    // The encoding doubles as the dir output for the LCD back-end.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic                last_up, last_up_nxt;
    logic [CNT_W-1:0]    travel_cnt, travel_cnt_nxt;
    logic [CNT_W-1:0]    dwell_cnt, dwell_cnt_nxt;
    logic [FLOOR_W-1:0]  cur_floor_nxt;
    logic                arrive_nxt;
    logic [N_FLOORS-1:0] pending_nxt;

    logic                req_in_range;
    logic                call_ok;
    logic                same_floor_door;
    logic [N_FLOORS-1:0] call_mask;
    logic [N_FLOORS-1:0] pend_merged;
    logic [N_FLOORS-1:0] clear_mask;

    logic [N_FLOORS-1:0] cur_mask;
    logic                cur_hit;
    logic                above;
    logic                below;

    logic [FLOOR_W-1:0]  new_floor;
    logic [N_FLOORS-1:0] new_mask;
    logic                new_hit;
    logic                ahead_up;
    logic                ahead_dn;

    // Call intake: range check and the one-hot bit an accepted call would set.
    always_comb begin
        req_in_range    = ({1'b0, req_floor} < FLOOR_LIMIT);
        call_ok         = req_valid && req_in_range;
        same_floor_door = call_ok && (state == DOOR_OPEN) && (req_floor == cur_floor);
        call_mask       = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (call_ok && !same_floor_door && (req_floor == FLOOR_W'(i)))
                call_mask[i] = 1'b1;
        end
        pend_merged = pending | call_mask;
    end

    // Registered call map relative to the current floor, used by IDLE.
    always_comb begin
        cur_mask = '0;
        above    = 1'b0;
        below    = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (FLOOR_W'(i) == cur_floor) cur_mask[i] = 1'b1;
            if (FLOOR_W'(i) >  cur_floor) above = above | pending[i];
            if (FLOOR_W'(i) <  cur_floor) below = below | pending[i];
        end
        cur_hit = |(pending & cur_mask);
    end

    // Stop check against the floor about to be reached, including this cycle's call.
    always_comb begin
        new_floor = (state == MOVE_DOWN) ? (cur_floor - FLOOR_W'(1))
                                         : (cur_floor + FLOOR_W'(1));
        new_mask  = '0;
        ahead_up  = 1'b0;
        ahead_dn  = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (FLOOR_W'(i) == new_floor) new_mask[i] = 1'b1;
            if (FLOOR_W'(i) >  new_floor) ahead_up = ahead_up | pend_merged[i];
            if (FLOOR_W'(i) <  new_floor) ahead_dn = ahead_dn | pend_merged[i];
        end
        new_hit = |(pend_merged & new_mask);
    end

    // Next-state, counters, floor update and call-map update.
    always_comb begin
        state_nxt      = state;
        last_up_nxt    = last_up;
        travel_cnt_nxt = travel_cnt;
        dwell_cnt_nxt  = dwell_cnt;
        cur_floor_nxt  = cur_floor;
        arrive_nxt     = 1'b0;
        clear_mask     = '0;

        case (state)
            IDLE: begin
                travel_cnt_nxt = '0;
                dwell_cnt_nxt  = '0;
                if (cur_hit) begin
                    clear_mask = cur_mask;
                    state_nxt  = DOOR_OPEN;
                end else if (above && (last_up || !below)) begin
                    state_nxt   = MOVE_UP;
                    last_up_nxt = 1'b1;
                end else if (below) begin
                    state_nxt   = MOVE_DOWN;
                    last_up_nxt = 1'b0;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    travel_cnt_nxt = '0;
                    cur_floor_nxt  = new_floor;
                    arrive_nxt     = 1'b1;
                    if (new_hit) begin
                        clear_mask    = new_mask;
                        dwell_cnt_nxt = '0;
                        state_nxt     = DOOR_OPEN;
                    end else if ((state == MOVE_UP) ? ahead_up : ahead_dn) begin
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    travel_cnt_nxt = travel_cnt + CNT_W'(1);
                end
            end

            DOOR_OPEN: begin
                if (same_floor_door) begin
                    dwell_cnt_nxt = '0;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt_nxt = '0;
                    state_nxt     = IDLE;
                end else begin
                    dwell_cnt_nxt = dwell_cnt + CNT_W'(1);
                end
            end

            default: state_nxt = IDLE;
        endcase

        // A floor being served at this edge wins over a new call for it.
        pending_nxt = pend_merged & ~clear_mask;
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state      <= IDLE;
            last_up    <= 1'b1;
            travel_cnt <= '0;
            dwell_cnt  <= '0;
            cur_floor  <= '0;
            pending    <= '0;
            arrive     <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_up    <= last_up_nxt;
            travel_cnt <= travel_cnt_nxt;
            dwell_cnt  <= dwell_cnt_nxt;
            cur_floor  <= cur_floor_nxt;
            pending    <= pending_nxt;
            arrive     <= arrive_nxt;
            req_err    <= req_valid && !req_in_range;
        end
    end

    // Status decode from the state register.
    always_comb begin
        moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
        door_open = (state == DOOR_OPEN);
        dir       = moving ? state : 2'd0;
    end

endmodule
